bus_arbiter: RTL and testbench

- Shares the single memory-mapped bus among NREQ requesters (CPU, DMA, …) using round-robin arbitration.
- Sequences one transaction at a time onto the bus that feeds the address decoder and devices: DRAM, DROM, DMAT, DINT, DREG, DEXEC, DSPI at 0x0000–0x6FFF.
- Uses the decoder's hit signal to reject unmapped addresses.
- Enforces a wait-state timeout and returns read data or an error to the owning requester.

---
 rtl/bus_arbiter_if.sv | 34 +++
 rtl/bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Requester and device-bus signals of the round-robin bus arbiter.
// The arbiter drives the bus, so it takes the master view; requesters and
// the decoder/device side together form the slave view.
interface bus_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 16,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               err;
  logic               bus_rd;
  logic               bus_wr;
  logic [AW-1:0]      bus_addr;
  logic [DW-1:0]      bus_wdata;
  logic               hit;
  logic               bus_ready;
  logic [DW-1:0]      bus_rdata;

  modport master (
    input  req, req_we, req_addr, req_wdata, hit, bus_ready, bus_rdata,
    output gnt, done, rdata, err, bus_rd, bus_wr, bus_addr, bus_wdata
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, hit, bus_ready, bus_rdata,
    input  gnt, done, rdata, err, bus_rd, bus_wr, bus_addr, bus_wdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that runs one transaction at a time onto the shared
// memory-mapped bus, rejects unmapped addresses via the decoder hit, and
// bounds device wait states with a timeout.
module bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.master bif
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic            we_q, we_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            bus_rd_q, bus_rd_d;
  logic            bus_wr_q, bus_wr_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            found;
  logic [OW-1:0]   sel;
  logic [OW-1:0]   arb_idx;
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  // Unpack the flat per-requester buses so the winner can be picked by index.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = bif.req_addr[g*AW +: AW];
    assign wdata_arr[g] = bif.req_wdata[g*DW +: DW];
  end

  // Round-robin pick: first requester set, starting just after the last owner.
  always_comb begin
    found   = 1'b0;
    sel     = last_q;
    arb_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      arb_idx = OW'((int'(last_q) + i) % NREQ);
      if (!found && bif.req[arb_idx]) begin
        found = 1'b1;
        sel   = arb_idx;
      end
    end
  end

  // Transaction sequencer: IDLE -> ACCESS -> DONE -> IDLE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    bus_rd_d    = bus_rd_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d      = sel;
          last_d       = sel;
          we_d         = bif.req_we[sel];
          bus_addr_d   = addr_arr[sel];
          bus_wdata_d  = wdata_arr[sel];
          gnt_d        = '0;
          gnt_d[sel]   = 1'b1;
          cnt_d        = '0;
          // Strobes are registered here so they cover every ACCESS cycle.
          bus_rd_d     = !bif.req_we[sel];
          bus_wr_d     = bif.req_we[sel];
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // Unmapped address beats a ready device; timeout only when neither.
        if (!bif.hit) begin
          err_d    = 1'b1;
          rdata_d  = '0;
          done_d   = gnt_q;
          bus_rd_d = 1'b0;
          bus_wr_d = 1'b0;
          state_d  = DONE;
        end else if (bif.bus_ready) begin
          err_d    = 1'b0;
          rdata_d  = we_q ? '0 : bif.bus_rdata;
          done_d   = gnt_q;
          bus_rd_d = 1'b0;
          bus_wr_d = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          rdata_d  = '0;
          done_d   = gnt_q;
          bus_rd_d = 1'b0;
          bus_wr_d = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Return every output to its idle value; only last_q survives.
        gnt_d       = '0;
        err_d       = 1'b0;
        rdata_d     = '0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        cnt_d       = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset also aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= OW'(NREQ - 1);
      we_q        <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bif.gnt       = gnt_q;
  assign bif.done      = done_q;
  assign bif.rdata     = rdata_q;
  assign bif.err       = err_q;
  assign bif.bus_rd    = bus_rd_q;
  assign bif.bus_wr    = bus_wr_q;
  assign bif.bus_addr  = bus_addr_q;
  assign bif.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single transactions, decoder miss,
// timeout, round-robin fairness and mid-transaction reset.
module tb_bus_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  bus_arbiter_if #(.NREQ(2), .AW(16), .DW(16)) bif ();

  bus_arbiter #(.NREQ(2), .AW(16), .DW(16), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  // Decoder model: devices occupy 0x0000-0x6FFF.
  assign bif.hit = (bif.bus_rd | bif.bus_wr) && (bif.bus_addr < 16'h7000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst           = 1'b1;
    bif.req       = '0;
    bif.req_we    = '0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One transaction from requester r; waits<0 means the device never responds.
  task automatic do_txn(input string nm, input int r, input logic we,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] devd, input int waits,
                        input int exp_lat, input int exp_stb,
                        input logic exp_err, input logic [15:0] exp_rd);
    int   acc;
    int   cyc;
    logic seen;
    bif.req_we[r]            = we;
    bif.req_addr[r*16 +: 16] = addr;
    bif.req_wdata[r*16 +: 16]= wd;
    bif.bus_rdata            = devd;
    bif.bus_ready            = 1'b0;
    bif.req[r]               = 1'b1;
    acc  = 0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 64) begin
      tick();
      cyc++;
      if (bif.bus_rd | bif.bus_wr) begin
        bif.bus_ready = (waits >= 0) && (acc >= waits);
        if (acc == 0) begin
          chk({nm, "_addr"}, 32'(bif.bus_addr), 32'(addr));
          chk({nm, "_gnt"}, 32'(bif.gnt), 1 << r);
          chk({nm, "_dir"}, 32'({bif.bus_rd, bif.bus_wr}), we ? 32'd1 : 32'd2);
          if (we) chk({nm, "_wdata"}, 32'(bif.bus_wdata), 32'(wd));
        end
        acc++;
      end else begin
        bif.bus_ready = 1'b0;
      end
      if (bif.done != 2'b00) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    chk({nm, "_done"}, 32'(bif.done), 1 << r);
    chk({nm, "_gnt_held"}, 32'(bif.gnt), 1 << r);
    chk({nm, "_lat"}, cyc, exp_lat);
    chk({nm, "_strobes"}, acc, exp_stb);
    chk({nm, "_err"}, 32'(bif.err), 32'(exp_err));
    chk({nm, "_rdata"}, 32'(bif.rdata), 32'(exp_rd));
    bif.req[r]    = 1'b0;
    bif.bus_ready = 1'b0;
    tick();
    chk({nm, "_idle_gnt"}, 32'(bif.gnt), 32'd0);
    chk({nm, "_idle_done"}, 32'(bif.done), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_done [4];
    int         exp_cyc  [4];
    int         k;
    int         cyc;
    int         multi;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;

    reset_dut();
    chk("rst_gnt", 32'(bif.gnt), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_strobe", 32'({bif.bus_rd, bif.bus_wr}), 32'd0);
    chk("rst_addr", 32'(bif.bus_addr), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);

    //       name  r we addr      wdata     devdata   waits lat stb err rdata
    do_txn("rd0",  0, 0, 16'h1ABC, 16'h0000, 16'hBEEF,  0,  2,  1, 0, 16'hBEEF);
    do_txn("wr0",  0, 1, 16'h4000, 16'h1234, 16'hFFFF,  3,  5,  4, 0, 16'h0000);
    do_txn("miss", 0, 0, 16'h7FFF, 16'h0000, 16'hDEAD,  0,  2,  1, 1, 16'h0000);
    do_txn("tmo",  0, 0, 16'h6000, 16'h0000, 16'hAAAA, -1, 17, 16, 1, 16'h0000);
    do_txn("post", 0, 0, 16'h0000, 16'h0000, 16'h5A5A,  0,  2,  1, 0, 16'h5A5A);
    do_txn("edge", 1, 0, 16'h6FFF, 16'h0000, 16'h0102,  1,  3,  2, 0, 16'h0102);
    do_txn("wmis", 1, 1, 16'h8000, 16'h9999, 16'h4444,  0,  2,  1, 1, 16'h0000);

    // Round-robin with both requesters held high after a fresh reset.
    reset_dut();
    exp_done[0] = 2'b01; exp_cyc[0] = 2;
    exp_done[1] = 2'b10; exp_cyc[1] = 5;
    exp_done[2] = 2'b01; exp_cyc[2] = 8;
    exp_done[3] = 2'b10; exp_cyc[3] = 11;
    bif.req_we    = 2'b00;
    bif.req_addr  = {16'h0200, 16'h0100};
    bif.bus_rdata = 16'h7777;
    bif.req       = 2'b11;
    k     = 0;
    cyc   = 0;
    multi = 0;
    while (k < 4 && cyc < 40) begin
      tick();
      cyc++;
      bif.bus_ready = bif.bus_rd | bif.bus_wr;
      if ($countones(bif.gnt) > 1) multi++;
      if (bif.done != 2'b00) begin
        chk("rr_done", 32'(bif.done), 32'(exp_done[k]));
        chk("rr_cyc", cyc, exp_cyc[k]);
        k++;
        if (k == 4) bif.req = 2'b00;
      end
    end
    chk("rr_count", k, 4);
    chk("rr_onehot", multi, 0);
    bif.bus_ready = 1'b0;
    tick();
    chk("rr_idle_gnt", 32'(bif.gnt), 32'd0);

    // Reset during ACCESS of a 0x5000 read.
    bif.req_we[0]        = 1'b0;
    bif.req_addr[15:0]   = 16'h5000;
    bif.req              = 2'b01;
    tick();
    chk("ra_rd", 32'(bif.bus_rd), 32'd1);
    rst     = 1'b1;
    bif.req = 2'b00;
    tick();
    chk("ra_gnt", 32'(bif.gnt), 32'd0);
    chk("ra_done", 32'(bif.done), 32'd0);
    chk("ra_rd_off", 32'({bif.bus_rd, bif.bus_wr}), 32'd0);
    chk("ra_addr", 32'(bif.bus_addr), 32'd0);
    rst                 = 1'b0;
    bif.req_addr[31:16] = 16'h0300;
    bif.req_we[1]       = 1'b0;
    bif.bus_rdata       = 16'h1357;
    bif.req             = 2'b10;
    tick();
    chk("ra_regrant", 32'(bif.gnt), 32'd2);
    bif.bus_ready = 1'b1;
    tick();
    chk("ra_redone", 32'(bif.done), 32'd2);
    chk("ra_rdata", 32'(bif.rdata), 32'h1357);
    bif.req       = 2'b00;
    bif.bus_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
